// File: rtl/board_referee_pkg.sv
// Shared encodings for the 3x3 board referee: cell marks, result codes,
// key code range, FSM states and the table of the eight winning lines.
package board_referee_pkg;

  localparam logic [1:0] CELL_EMPTY = 2'b00;
  localparam logic [1:0] CELL_X     = 2'b01;
  localparam logic [1:0] CELL_O     = 2'b10;

  localparam logic [1:0] GE_RUN  = 2'b00;
  localparam logic [1:0] GE_X    = 2'b01;
  localparam logic [1:0] GE_O    = 2'b10;
  localparam logic [1:0] GE_DRAW = 2'b11;

  localparam logic [3:0] KEY_NONE     = 4'd0;
  localparam logic [3:0] KEY_CELL_MIN = 4'd1;
  localparam logic [3:0] KEY_CELL_MAX = 4'd9;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PLAY  = 2'd1,
    ST_CHECK = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  // Zero-based cell index of position pos (0..2) on line (0..7):
  // lines 0..2 are rows, 3..5 columns, 6 the main diagonal, 7 the anti-diagonal.
  function automatic int line_cell(input int line, input int pos);
    if (line < 3)       return line * 3 + pos;
    else if (line < 6)  return pos * 3 + (line - 3);
    else if (line == 6) return pos * 4;
    else                return 2 + pos * 2;
  endfunction

endpackage

// File: rtl/board_referee_win_checker.sv
// Combinational line evaluator: reports which mark owns a complete line
// (or EMPTY) and whether every cell is occupied. Also usable by the renderer.
module board_referee_win_checker
  import board_referee_pkg::*;
(
  input  logic [17:0] board,
  output logic [1:0]  winner,
  output logic        full
);

  logic [7:0] line_x;
  logic [7:0] line_o;
  logic [8:0] occupied;

  genvar gi;

  // One comparator triple per line, cell positions taken from the line table.
  generate
    for (gi = 0; gi < 8; gi++) begin : g_line
      localparam int C0 = line_cell(gi, 0);
      localparam int C1 = line_cell(gi, 1);
      localparam int C2 = line_cell(gi, 2);
      assign line_x[gi] = (board[2*C0 +: 2] == CELL_X) &&
                          (board[2*C1 +: 2] == CELL_X) &&
                          (board[2*C2 +: 2] == CELL_X);
      assign line_o[gi] = (board[2*C0 +: 2] == CELL_O) &&
                          (board[2*C1 +: 2] == CELL_O) &&
                          (board[2*C2 +: 2] == CELL_O);
    end
    for (gi = 0; gi < 9; gi++) begin : g_cell
      assign occupied[gi] = (board[2*gi +: 2] != CELL_EMPTY);
    end
  endgenerate

  // Only the player who just moved can complete a line, so priority is moot.
  always_comb begin
    winner = CELL_EMPTY;
    if (|line_x)      winner = CELL_X;
    else if (|line_o) winner = CELL_O;
    full = &occupied;
  end

endmodule

// File: rtl/board_referee.sv
// Game-rule engine: turns keypad presses into moves on a 3x3 grid, runs the
// per-move BCD countdown with forfeit on timeout, and reports win/draw.
module board_referee
  import board_referee_pkg::*;
#(
  parameter int TICKS_PER_SEC = 100,
  parameter int MOVE_TIME     = 15
) (
  input  logic        keypad_clock,
  input  logic        reset,
  input  logic        start,
  input  logic [3:0]  key_code,
  output logic [17:0] board,
  output logic        turn,
  output logic [1:0]  game_end,
  output logic [3:0]  time_ten,
  output logic [3:0]  time_one,
  output logic        move_ok
);

  localparam int         TICK_W     = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
  localparam logic [3:0] RELOAD_TEN = 4'(MOVE_TIME / 10);
  localparam logic [3:0] RELOAD_ONE = 4'(MOVE_TIME % 10);

  state_t             state_reg;
  logic [3:0]         prev_key_reg;
  logic [TICK_W-1:0]  tick_reg;

  logic               press_evt;
  logic               key_is_cell;
  logic [3:0]         cell_index;
  logic               cell_empty;
  logic               move_valid;
  logic               tick_wrap;
  logic               time_zero;
  logic [1:0]         win_winner;
  logic               win_full;

  board_referee_win_checker u_win_checker (
    .board  (board),
    .winner (win_winner),
    .full   (win_full)
  );

  // Edge-detect the key, decode the addressed cell and its occupancy.
  always_comb begin
    press_evt   = (key_code != KEY_NONE) && (prev_key_reg == KEY_NONE);
    key_is_cell = (key_code >= KEY_CELL_MIN) && (key_code <= KEY_CELL_MAX);
    cell_index  = key_code - 4'd1;
    cell_empty  = 1'b0;
    for (int k = 0; k < 9; k++) begin
      if (cell_index == 4'(k)) cell_empty = (board[2*k +: 2] == CELL_EMPTY);
    end
    move_valid  = press_evt && key_is_cell && cell_empty;
    tick_wrap   = (tick_reg == TICK_W'(TICKS_PER_SEC - 1));
    time_zero   = (time_ten == 4'd0) && (time_one == 4'd0);
  end

  // Previous key code, sampled every cycle so holds never re-trigger.
  always_ff @(posedge keypad_clock or negedge reset) begin
    if (!reset) prev_key_reg <= KEY_NONE;
    else        prev_key_reg <= key_code;
  end

  // Game FSM with registered board, turn, result, timer and move pulse.
  always_ff @(posedge keypad_clock or negedge reset) begin
    if (!reset) begin
      state_reg <= ST_IDLE;
      board     <= '0;
      turn      <= 1'b0;
      game_end  <= GE_RUN;
      time_ten  <= RELOAD_TEN;
      time_one  <= RELOAD_ONE;
      tick_reg  <= '0;
      move_ok   <= 1'b0;
    end else begin
      move_ok <= 1'b0;
      if (!start || state_reg == ST_IDLE) begin
        // Idle (or start dropped): hold a fresh game, begin once start is high.
        board     <= '0;
        turn      <= 1'b0;
        game_end  <= GE_RUN;
        time_ten  <= RELOAD_TEN;
        time_one  <= RELOAD_ONE;
        tick_reg  <= '0;
        state_reg <= start ? ST_PLAY : ST_IDLE;
      end else begin
        case (state_reg)
          ST_PLAY: begin
            if (move_valid) begin
              // A valid press beats a timeout landing on the same edge.
              for (int k = 0; k < 9; k++) begin
                if (cell_index == 4'(k)) board[2*k +: 2] <= turn ? CELL_O : CELL_X;
              end
              move_ok   <= 1'b1;
              state_reg <= ST_CHECK;
            end else if (tick_wrap) begin
              tick_reg <= '0;
              if (time_zero) begin
                turn     <= ~turn;
                time_ten <= RELOAD_TEN;
                time_one <= RELOAD_ONE;
              end else if (time_one == 4'd0) begin
                time_one <= 4'd9;
                time_ten <= time_ten - 4'd1;
              end else begin
                time_one <= time_one - 4'd1;
              end
            end else begin
              tick_reg <= tick_reg + TICK_W'(1);
            end
          end
          ST_CHECK: begin
            if (win_winner != CELL_EMPTY) begin
              game_end  <= win_winner;
              state_reg <= ST_DONE;
            end else if (win_full) begin
              game_end  <= GE_DRAW;
              state_reg <= ST_DONE;
            end else begin
              turn      <= ~turn;
              time_ten  <= RELOAD_TEN;
              time_one  <= RELOAD_ONE;
              tick_reg  <= '0;
              state_reg <= ST_PLAY;
            end
          end
          ST_DONE: state_reg <= ST_DONE;
          default: state_reg <= ST_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_board_referee.sv
// Bench for board_referee: directed game scenarios plus random key traffic,
// each cycle compared with a game-level model of the rules.
module tb_board_referee;

  localparam int TPS = 100;
  localparam int MT  = 15;

  logic        keypad_clock = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic [3:0]  key_code = 4'd0;
  logic [17:0] board;
  logic        turn;
  logic [1:0]  game_end;
  logic [3:0]  time_ten;
  logic [3:0]  time_one;
  logic        move_ok;

  int errors = 0;
  int checks = 0;

  // Model: phase 0 idle, 1 playing, 2 judging the last move, 3 finished.
  int m_cells [9];
  int m_turn, m_end, m_phase, m_left, m_tick, m_prev, m_ok;

  always #5 keypad_clock = ~keypad_clock;

  board_referee #(.TICKS_PER_SEC(TPS), .MOVE_TIME(MT)) dut (
    .keypad_clock (keypad_clock),
    .reset        (reset),
    .start        (start),
    .key_code     (key_code),
    .board        (board),
    .turn         (turn),
    .game_end     (game_end),
    .time_ten     (time_ten),
    .time_one     (time_one),
    .move_ok      (move_ok)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic void new_game();
    for (int i = 0; i < 9; i++) m_cells[i] = 0;
    m_turn = 0; m_end = 0; m_left = MT; m_tick = 0; m_ok = 0;
  endfunction

  function automatic void model_reset();
    new_game();
    m_phase = 0; m_prev = 0;
  endfunction

  // Mark owning a complete line, 0 if none.
  function automatic int model_winner();
    for (int r = 0; r < 3; r++) begin
      if (m_cells[3*r] != 0 && m_cells[3*r] == m_cells[3*r+1] && m_cells[3*r] == m_cells[3*r+2])
        return m_cells[3*r];
      if (m_cells[r] != 0 && m_cells[r] == m_cells[r+3] && m_cells[r] == m_cells[r+6])
        return m_cells[r];
    end
    if (m_cells[4] != 0 && m_cells[0] == m_cells[4] && m_cells[8] == m_cells[4]) return m_cells[4];
    if (m_cells[4] != 0 && m_cells[2] == m_cells[4] && m_cells[6] == m_cells[4]) return m_cells[4];
    return 0;
  endfunction

  function automatic void model_step(input logic s, input logic [3:0] k);
    bit press;
    bit filled;
    press = (k != 0) && (m_prev == 0);
    m_ok = 0;
    if (!s || m_phase == 0) begin
      new_game();
      m_phase = s ? 1 : 0;
    end else if (m_phase == 1) begin
      if (press && k >= 1 && k <= 9 && m_cells[k-1] == 0) begin
        m_cells[k-1] = m_turn + 1;
        m_ok = 1;
        m_phase = 2;
      end else begin
        m_tick++;
        if (m_tick == TPS) begin
          m_tick = 0;
          if (m_left == 0) begin m_turn ^= 1; m_left = MT; end
          else m_left--;
        end
      end
    end else if (m_phase == 2) begin
      filled = 1;
      for (int i = 0; i < 9; i++) if (m_cells[i] == 0) filled = 0;
      if (model_winner() != 0) begin m_end = model_winner(); m_phase = 3; end
      else if (filled) begin m_end = 3; m_phase = 3; end
      else begin m_turn ^= 1; m_left = MT; m_tick = 0; m_phase = 1; end
    end
    m_prev = k;
  endfunction

  task automatic compare_all();
    logic [17:0] b;
    for (int i = 0; i < 9; i++) b[2*i +: 2] = 2'(m_cells[i]);
    check("board", 32'(board), 32'(b));
    check("turn", 32'(turn), 32'(m_turn));
    check("game_end", 32'(game_end), 32'(m_end));
    check("time_ten", 32'(time_ten), 32'(m_left / 10));
    check("time_one", 32'(time_one), 32'(m_left % 10));
    check("move_ok", 32'(move_ok), 32'(m_ok));
  endtask

  task automatic cycle(input logic s, input logic [3:0] k);
    start = s;
    key_code = k;
    @(posedge keypad_clock);
    model_step(s, k);
    #1;
    compare_all();
  endtask

  task automatic press(input logic [3:0] k);
    cycle(1'b1, k); cycle(1'b1, k); cycle(1'b1, 4'd0); cycle(1'b1, 4'd0);
  endtask

  task automatic fresh_game();
    cycle(1'b0, 4'd0);
    cycle(1'b1, 4'd0);
  endtask

  int         okc;
  logic [3:0] rk;
  int         rlen;
  logic       rs;

  initial begin
    model_reset();
    // Reset state
    repeat (3) @(posedge keypad_clock);
    #1;
    check("rst_board", 32'(board), 32'd0);
    check("rst_turn", 32'(turn), 32'd0);
    check("rst_end", 32'(game_end), 32'd0);
    check("rst_ten", 32'(time_ten), 32'd1);
    check("rst_one", 32'(time_one), 32'd5);
    check("rst_ok", 32'(move_ok), 32'd0);
    reset = 1'b1;
    $display("reset released");

    // Held key 5 makes exactly one move
    cycle(1'b1, 4'd0); cycle(1'b1, 4'd0);
    okc = 0;
    cycle(1'b1, 4'd5);
    if (move_ok === 1'b1) okc++;
    check("hold_cell5", 32'(board[9:8]), 32'd1);
    check("hold_turn_edge1", 32'(turn), 32'd0);
    cycle(1'b1, 4'd5);
    check("hold_turn_edge2", 32'(turn), 32'd1);
    check("hold_reload", 32'({time_ten, time_one}), 32'h15);
    for (int i = 0; i < 18; i++) begin
      cycle(1'b1, 4'd5);
      if (move_ok === 1'b1) okc++;
    end
    check("hold_one_pulse", 32'(okc), 32'd1);
    cycle(1'b1, 4'd0);
    $display("hold key 5: board=%h turn=%0d", board, turn);

    // Occupied cell and out-of-range code
    okc = 0;
    for (int i = 0; i < 4; i++) begin cycle(1'b1, (i < 2) ? 4'd5 : 4'd0); if (move_ok === 1'b1) okc++; end
    for (int i = 0; i < 4; i++) begin cycle(1'b1, (i < 2) ? 4'd12 : 4'd0); if (move_ok === 1'b1) okc++; end
    check("ignore_pulses", 32'(okc), 32'd0);
    check("ignore_board", 32'(board), 32'h00100);
    check("ignore_turn", 32'(turn), 32'd1);
    $display("occupied/ignored presses: board=%h turn=%0d", board, turn);

    // Timeout forfeits the move
    cycle(1'b0, 4'd0);
    check("drop_board", 32'(board), 32'd0);
    check("drop_turn", 32'(turn), 32'd0);
    cycle(1'b1, 4'd0);
    for (int i = 0; i < 16 * TPS - 1; i++) cycle(1'b1, 4'd0);
    check("to_zero", 32'({time_ten, time_one}), 32'h00);
    check("to_turn_before", 32'(turn), 32'd0);
    cycle(1'b1, 4'd0);
    check("to_turn_after", 32'(turn), 32'd1);
    check("to_reload", 32'({time_ten, time_one}), 32'h15);
    check("to_board", 32'(board), 32'd0);
    $display("timeout forfeit: turn=%0d time=%0d%0d", turn, time_ten, time_one);

    // Press on the timeout edge wins
    for (int i = 0; i < 16 * TPS - 1; i++) cycle(1'b1, 4'd0);
    cycle(1'b1, 4'd3);
    check("race_cell3", 32'(board[5:4]), 32'd2);
    check("race_ok", 32'(move_ok), 32'd1);
    cycle(1'b1, 4'd3);
    check("race_turn", 32'(turn), 32'd0);
    check("race_reload", 32'({time_ten, time_one}), 32'h15);
    cycle(1'b1, 4'd0);
    $display("press vs timeout: board=%h turn=%0d", board, turn);

    // X wins on the top row
    fresh_game();
    press(4'd1); press(4'd4); press(4'd2); press(4'd5); press(4'd3);
    check("win_end", 32'(game_end), 32'd1);
    check("win_board", 32'(board), 32'h00295);
    press(4'd9);
    check("win_frozen_cell9", 32'(board[17:16]), 32'd0);
    check("win_frozen_end", 32'(game_end), 32'd1);
    check("win_frozen_turn", 32'(turn), 32'd0);
    $display("x wins: board=%h game_end=%0d", board, game_end);

    // Draw
    fresh_game();
    press(4'd1); press(4'd2); press(4'd3); press(4'd5); press(4'd4);
    press(4'd6); press(4'd8); press(4'd7);
    check("draw_pending", 32'(game_end), 32'd0);
    press(4'd9);
    check("draw_end", 32'(game_end), 32'd3);
    $display("draw: board=%h game_end=%0d", board, game_end);

    // start drop mid-game, then async reset mid-cycle
    fresh_game();
    press(4'd1); press(4'd2);
    cycle(1'b0, 4'd0);
    check("mid_drop_board", 32'(board), 32'd0);
    check("mid_drop_turn", 32'(turn), 32'd0);
    check("mid_drop_end", 32'(game_end), 32'd0);
    cycle(1'b1, 4'd0);
    press(4'd5);
    cycle(1'b1, 4'd0);
    @(negedge keypad_clock);
    #2;
    reset = 1'b0;
    #1;
    check("async_board", 32'(board), 32'd0);
    check("async_turn", 32'(turn), 32'd0);
    check("async_time", 32'({time_ten, time_one}), 32'h15);
    model_reset();
    @(posedge keypad_clock);
    #1;
    reset = 1'b1;
    $display("async reset: board=%h turn=%0d", board, turn);

    // Random key traffic
    for (int n = 0; n < 3000; ) begin
      rk   = ($urandom_range(0, 1) == 0) ? 4'd0 : 4'($urandom_range(1, 15));
      rlen = $urandom_range(1, 3);
      rs   = !(m_phase == 3 && $urandom_range(0, 3) == 0) && ($urandom_range(0, 299) != 0);
      for (int j = 0; j < rlen; j++) begin
        cycle(rs, rk);
        n++;
      end
    end
    $display("random traffic done");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
